wb_stage: RTL and testbench

- Write-back stage; consumes the MEM/WB pipeline register outputs and drives the register-file write port.
- Forms the register write-back value from the ALU, memory (with byte/halfword extraction), HI/LO or the link address.
- Owns the architectural HI/LO registers and implements syscall halt/display.
- Keeps retired-instruction and load counters for the debug display.

---
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects the register-file write value and owns the HI/LO registers.
// Also handles syscall halt/display and keeps the retired-instruction and load counters.
module wb_stage #(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32,
    parameter int HALT_CODE = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_BITS-1:0]   PC_in,
    input  logic [IR_BITS-1:0]   IR_in,
    input  logic                 Jal,
    input  logic                 MemToReg,
    input  logic                 RegWrite,
    input  logic [1:0]           ExtrWord,
    input  logic                 ExtrSigned,
    input  logic                 ToLH,
    input  logic [1:0]           LHToReg,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] alu_out2,
    input  logic [DATA_BITS-1:0] mem_out,
    input  logic [DATA_BITS-1:0] lo,
    input  logic [DATA_BITS-1:0] hi,
    input  logic [5:0]           write,
    input  logic                 ld,
    input  logic                 Syscall,
    input  logic [DATA_BITS-1:0] v0_val,
    input  logic [DATA_BITS-1:0] a0_val,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [DATA_BITS-1:0] rf_wdata,
    output logic [DATA_BITS-1:0] hi_reg,
    output logic [DATA_BITS-1:0] lo_reg,
    output logic                 halted,
    output logic [DATA_BITS-1:0] disp_data,
    output logic                 disp_valid,
    output logic [CNT_BITS-1:0]  instr_count,
    output logic [CNT_BITS-1:0]  load_count
);

    logic [DATA_BITS-1:0] hi_q, hi_d;
    logic [DATA_BITS-1:0] lo_q, lo_d;
    logic                 halted_q, halted_d;
    logic [DATA_BITS-1:0] disp_data_q, disp_data_d;
    logic                 disp_valid_q, disp_valid_d;
    logic [CNT_BITS-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_BITS-1:0]  load_cnt_q, load_cnt_d;

    logic                 retire;
    logic                 halt_call;
    logic [PC_BITS-1:0]   pc_plus4;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [DATA_BITS-1:0] ext;

    // alu_out2 and write[5] are carried through the pipeline for visibility only.
    logic unused_bits;
    assign unused_bits = ^{alu_out2, write[5]};

    assign retire    = (IR_in != '0) && !halted_q;
    assign halt_call = (v0_val == DATA_BITS'(HALT_CODE));
    assign pc_plus4  = PC_in + PC_BITS'(4);

    assign rf_we    = RegWrite && retire && (write[4:0] != 5'd0);
    assign rf_waddr = write[4:0];

    // Little-endian lane select driven by the low address bits.
    assign byte_sel = mem_out[{alu_out[1:0], 3'b000} +: 8];
    assign half_sel = mem_out[{alu_out[1], 4'b0000} +: 16];

    always_comb begin
        unique case (ExtrWord)
            2'b01:   ext = {{(DATA_BITS-8){ExtrSigned & byte_sel[7]}}, byte_sel};
            2'b10:   ext = {{(DATA_BITS-16){ExtrSigned & half_sel[15]}}, half_sel};
            default: ext = mem_out;
        endcase
    end

    always_comb begin
        if (Jal)                  rf_wdata = DATA_BITS'(pc_plus4);
        else if (LHToReg == 2'b01) rf_wdata = lo_q;
        else if (LHToReg == 2'b10) rf_wdata = hi_q;
        else if (MemToReg)        rf_wdata = ext;
        else                      rf_wdata = alu_out;
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latch).
        hi_d         = hi_q;
        lo_d         = lo_q;
        halted_d     = halted_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        instr_cnt_d  = instr_cnt_q;
        load_cnt_d   = load_cnt_q;
        if (retire) begin
            instr_cnt_d = instr_cnt_q + CNT_BITS'(1);
            if (ld) load_cnt_d = load_cnt_q + CNT_BITS'(1);
            if (ToLH) begin
                hi_d = hi;
                lo_d = lo;
            end
            if (Syscall) begin
                if (halt_call) begin
                    halted_d = 1'b1;
                end else begin
                    disp_data_d  = a0_val;
                    disp_valid_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q         <= '0;
            lo_q         <= '0;
            halted_q     <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            instr_cnt_q  <= '0;
            load_cnt_q   <= '0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            halted_q     <= halted_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            instr_cnt_q  <= instr_cnt_d;
            load_cnt_q   <= load_cnt_d;
        end
    end

    assign hi_reg      = hi_q;
    assign lo_reg      = lo_q;
    assign halted      = halted_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign instr_count = instr_cnt_q;
    assign load_count  = load_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against a behavioural model.
// A second, narrow-counter instance exercises counter wrap-around.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] PC_in, IR_in, alu_out, alu_out2, mem_out, lo, hi, v0_val, a0_val;
    logic        Jal, MemToReg, RegWrite, ExtrSigned, ToLH, ld, Syscall;
    logic [1:0]  ExtrWord, LHToReg;
    logic [5:0]  write;

    logic        rf_we, halted, disp_valid;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi_reg, lo_reg, disp_data, instr_count, load_count;

    logic        w_rf_we, w_halted, w_disp_valid;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata, w_hi_reg, w_lo_reg, w_disp_data;
    logic [2:0]  w_instr_count, w_load_count;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .IR_in(IR_in), .Jal(Jal),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ExtrWord(ExtrWord),
        .ExtrSigned(ExtrSigned), .ToLH(ToLH), .LHToReg(LHToReg), .alu_out(alu_out),
        .alu_out2(alu_out2), .mem_out(mem_out), .lo(lo), .hi(hi), .write(write),
        .ld(ld), .Syscall(Syscall), .v0_val(v0_val), .a0_val(a0_val),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_reg(hi_reg),
        .lo_reg(lo_reg), .halted(halted), .disp_data(disp_data),
        .disp_valid(disp_valid), .instr_count(instr_count), .load_count(load_count)
    );

    wb_stage #(.CNT_BITS(3)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .IR_in(IR_in), .Jal(Jal),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ExtrWord(ExtrWord),
        .ExtrSigned(ExtrSigned), .ToLH(ToLH), .LHToReg(LHToReg), .alu_out(alu_out),
        .alu_out2(alu_out2), .mem_out(mem_out), .lo(lo), .hi(hi), .write(write),
        .ld(ld), .Syscall(Syscall), .v0_val(v0_val), .a0_val(a0_val),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata), .hi_reg(w_hi_reg),
        .lo_reg(w_lo_reg), .halted(w_halted), .disp_data(w_disp_data),
        .disp_valid(w_disp_valid), .instr_count(w_instr_count), .load_count(w_load_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural reference state.
    logic [31:0] m_hi, m_lo, m_disp;
    logic        m_halted, m_dv;
    longint      m_cnt, m_ld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_ext();
        logic [31:0] v;
        if (ExtrWord == 2'b01) begin
            v = (mem_out >> (8 * alu_out[1:0])) & 32'h0000_00FF;
            if (ExtrSigned && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ExtrWord == 2'b10) begin
            v = (mem_out >> (alu_out[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (ExtrSigned && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem_out;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata();
        if (Jal) return PC_in + 32'd4;
        if (LHToReg == 2'b01) return m_lo;
        if (LHToReg == 2'b10) return m_hi;
        if (MemToReg) return model_ext();
        return alu_out;
    endfunction

    task automatic idle();
        PC_in = 32'h0040_0000; IR_in = 32'h0; alu_out = '0; alu_out2 = '0; mem_out = '0;
        lo = '0; hi = '0; v0_val = '0; a0_val = '0; Jal = 0; MemToReg = 0; RegWrite = 0;
        ExtrSigned = 0; ToLH = 0; ld = 0; Syscall = 0; ExtrWord = 2'b00; LHToReg = 2'b00;
        write = 6'd0;
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_disp = '0; m_halted = 0; m_dv = 0; m_cnt = 0; m_ld = 0;
    endtask

    // Inputs are applied at the negedge; checks happen 1 ns later and 1 ns after the posedge.
    task automatic step();
        logic retire;
        retire = (IR_in != 0) && !m_halted;
        #1;
        check("rf_we", rf_we, RegWrite && retire && (write[4:0] != 0));
        check("rf_waddr", rf_waddr, write[4:0]);
        check("rf_wdata", rf_wdata, model_wdata());
        @(posedge clk);
        m_dv = 0;
        if (retire) begin
            m_cnt = m_cnt + 1;
            if (ld) m_ld = m_ld + 1;
            if (ToLH) begin m_hi = hi; m_lo = lo; end
            if (Syscall) begin
                if (v0_val == 32'd10) m_halted = 1;
                else begin m_disp = a0_val; m_dv = 1; end
            end
        end
        #1;
        check("hi_reg", hi_reg, m_hi);
        check("lo_reg", lo_reg, m_lo);
        check("halted", halted, m_halted);
        check("disp_data", disp_data, m_disp);
        check("disp_valid", disp_valid, m_dv);
        check("instr_count", instr_count, m_cnt[31:0]);
        check("load_count", load_count, m_ld[31:0]);
        check("wrap_instr_count", w_instr_count, 32'(m_cnt % 8));
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("rst_instr_count", instr_count, 0);
        check("rst_load_count", load_count, 0);
        check("rst_hi", hi_reg, 0);
        check("rst_lo", lo_reg, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic alu_op(input logic [31:0] val, input logic [5:0] dst);
        idle(); IR_in = 32'h0000_0020; RegWrite = 1; alu_out = val; write = dst;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        #1;
        check("reset_instr_count", instr_count, 0);
        check("reset_halted", halted, 0);
        rst_n = 1;
        @(negedge clk);

        // Five retirements including HI/LO load and a display syscall, then reset mid-run.
        for (int i = 0; i < 4; i++) begin
            alu_op(32'h100 + i, 6'(i + 2)); ToLH = (i == 1); hi = 32'hAAAA; lo = 32'h5555; ld = (i == 2);
            step();
        end
        idle(); IR_in = 32'h0000_000C; Syscall = 1; v0_val = 1; a0_val = 7;
        step();
        check("five_retired", instr_count, 5);
        idle();
        async_reset();

        // Byte / halfword extraction.
        idle(); IR_in = 32'h8000_0000; RegWrite = 1; MemToReg = 1; ld = 1; write = 6'd8;
        mem_out = 32'h80FF_7F01; alu_out = 32'h1003; ExtrWord = 2'b01; ExtrSigned = 1;
        #1 check("lb_signed", rf_wdata, 32'hFFFF_FF80);
        step();
        ExtrSigned = 0;
        #1 check("lbu", rf_wdata, 32'h0000_0080);
        step();
        ExtrWord = 2'b10; ExtrSigned = 1; alu_out = 32'h1002;
        #1 check("lh_signed", rf_wdata, 32'hFFFF_80FF);
        step();

        // mult then mflo / mfhi.
        idle(); IR_in = 32'h0000_0018; ToLH = 1; lo = 32'h1234_5678; hi = 32'h1;
        step();
        idle(); IR_in = 32'h0000_0012; RegWrite = 1; LHToReg = 2'b01; write = 6'd9;
        #1 check("mflo", rf_wdata, 32'h1234_5678);
        step();
        LHToReg = 2'b10;
        #1 check("mfhi", rf_wdata, 32'h0000_0001);
        step();

        // Jal link write.
        idle(); IR_in = 32'h0C00_0000; Jal = 1; RegWrite = 1; write = 6'd31; PC_in = 32'h0040_0010;
        #1 check("jal_we", rf_we, 1);
        check("jal_waddr", rf_waddr, 31);
        check("jal_wdata", rf_wdata, 32'h0040_0014);
        step();

        // Register 0 and bubble.
        alu_op(32'hDEAD, 6'd0);
        #1 check("r0_we", rf_we, 0);
        step();
        alu_op(32'hBEEF, 6'd5); IR_in = 0;
        #1 check("bubble_we", rf_we, 0);
        step();

        // Syscall display then halt.
        idle();
        async_reset();
        idle(); IR_in = 32'h0000_000C; Syscall = 1; v0_val = 1; a0_val = 42;
        step();
        check("disp_42", disp_data, 42);
        idle(); IR_in = 32'h0000_000C; Syscall = 1; v0_val = 10;
        #1;
        check("pulse_one_cycle", disp_valid, 1);
        step();
        check("pulse_dropped", disp_valid, 0);
        check("halted_set", halted, 1);
        check("halt_count", instr_count, 2);
        for (int i = 0; i < 3; i++) begin
            alu_op(32'h77, 6'd4); ToLH = 1; hi = 32'h99; ld = 1;
            step();
        end
        check("frozen_count", instr_count, 2);

        // Counter wrap on the 3-bit instance.
        idle();
        async_reset();
        for (int i = 0; i < 8; i++) begin
            alu_op(i, 6'd3);
            step();
        end
        check("wrap_zero", w_instr_count, 0);
        check("wide_eight", instr_count, 8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            IR_in      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            PC_in      = $urandom;
            Jal        = ($urandom_range(0, 7) == 0);
            MemToReg   = $urandom_range(0, 1);
            RegWrite   = $urandom_range(0, 1);
            ExtrWord   = 2'($urandom_range(0, 3));
            ExtrSigned = $urandom_range(0, 1);
            ToLH       = ($urandom_range(0, 3) == 0);
            LHToReg    = 2'($urandom_range(0, 3));
            alu_out    = $urandom;
            alu_out2   = $urandom;
            mem_out    = $urandom;
            lo         = $urandom;
            hi         = $urandom;
            write      = 6'($urandom_range(0, 63));
            ld         = $urandom_range(0, 1);
            Syscall    = ($urandom_range(0, 5) == 0);
            v0_val     = ($urandom_range(0, 15) == 0) ? 32'd10 : $urandom_range(0, 9);
            a0_val     = $urandom;
            step();
            if (m_halted && $urandom_range(0, 3) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
